// File: rtl/sdram_pkg.sv
// Shared definitions for the SDR-SDRAM device responder: command decode,
// mode-register field layout, burst-length and CAS-latency encodings.
package sdram_pkg;

    typedef enum logic [2:0] {
        CMD_NOP,
        CMD_ACTIVE,
        CMD_READ,
        CMD_WRITE,
        CMD_PRECHARGE,
        CMD_AUTO_REFRESH,
        CMD_LOAD_MODE,
        CMD_BURST_STOP
    } sdram_cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE
    } burst_state_e;

    localparam int MR_BL_LSB   = 0;
    localparam int MR_BL_MSB   = 2;
    localparam int MR_CL_LSB   = 4;
    localparam int MR_CL_MSB   = 6;
    localparam int PRE_ALL_BIT = 10;

    localparam logic [2:0] BL_1 = 3'd0;
    localparam logic [2:0] BL_2 = 3'd1;
    localparam logic [2:0] BL_4 = 3'd2;
    localparam logic [2:0] BL_8 = 3'd3;

    localparam logic [2:0] CL_2 = 3'd2;
    localparam logic [2:0] CL_3 = 3'd3;

    function automatic sdram_cmd_e decode_cmd(input logic cs_n, input logic ras_n,
                                              input logic cas_n, input logic we_n);
        sdram_cmd_e c;
        c = CMD_NOP;
        if (!cs_n) begin
            case ({ras_n, cas_n, we_n})
                3'b011:  c = CMD_ACTIVE;
                3'b101:  c = CMD_READ;
                3'b100:  c = CMD_WRITE;
                3'b010:  c = CMD_PRECHARGE;
                3'b001:  c = CMD_AUTO_REFRESH;
                3'b000:  c = CMD_LOAD_MODE;
                3'b110:  c = CMD_BURST_STOP;
                default: c = CMD_NOP;
            endcase
        end
        return c;
    endfunction

    // BL-1, doubling as the column wrap mask inside a burst block.
    function automatic logic [2:0] bl_mask(input logic [1:0] bl_code);
        logic [2:0] m;
        case ({1'b0, bl_code})
            BL_1:    m = 3'b000;
            BL_2:    m = 3'b001;
            BL_4:    m = 3'b011;
            BL_8:    m = 3'b111;
            default: m = 3'b000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/sdram_resp_store.sv
// Backing word store for the responder: byte-masked write, registered read.
// Contents are intentionally not reset.
module sdram_resp_store #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_AW     = 10
) (
    input  logic                    clk,
    input  logic                    en,
    input  logic                    we,
    input  logic [MEM_AW-1:0]       waddr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wbe,
    input  logic                    re,
    input  logic [MEM_AW-1:0]       raddr,
    output logic [DATA_WIDTH-1:0]   rdata
);
    localparam int BYTES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [2**MEM_AW];

    always_ff @(posedge clk) begin
        if (en && we) begin
            for (int i = 0; i < BYTES; i++) begin
                if (wbe[i]) mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (en && re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/sdram_responder.sv
// SDR-SDRAM device-side responder: command decode, bank/row table, burst
// sequencer and CAS-latency read pipeline in front of a small word store.
//
//  state    | meaning
//  ST_IDLE  | no burst in progress (single-beat bursts never leave idle)
//  ST_READ  | issuing read beats 1..BL-1 into the CAS pipeline
//  ST_WRITE | capturing write beats 1..BL-1 from dq_in
module sdram_responder
    import sdram_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DQM_WIDTH  = 4,
    parameter int ADDR_WIDTH = 12,
    parameter int BA_WIDTH   = 2,
    parameter int COL_WIDTH  = 8,
    parameter int MEM_AW     = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cke,
    input  logic                   cs_n,
    input  logic                   ras_n,
    input  logic                   cas_n,
    input  logic                   we_n,
    input  logic [BA_WIDTH-1:0]    ba,
    input  logic [ADDR_WIDTH-1:0]  addr,
    input  logic [DQM_WIDTH-1:0]   dqm,
    input  logic [DATA_WIDTH-1:0]  dq_in,
    output logic [DATA_WIDTH-1:0]  dq_out,
    output logic                   dq_oe,
    output logic [2**BA_WIDTH-1:0] bank_open,
    output logic                   err,
    output logic [15:0]            refresh_cnt
);
    localparam int NB      = 2**BA_WIDTH;
    localparam int FULL_AW = BA_WIDTH + ADDR_WIDTH + COL_WIDTH;

    sdram_cmd_e   cmd;
    burst_state_e state, state_n;

    logic [1:0]            bl_code;
    logic                  cl3;
    logic [ADDR_WIDTH-1:0] row_tbl [NB];

    logic [2:0]            beat_left, beat_left_n;
    logic [2:0]            beat_idx, beat_idx_n;
    logic [2:0]            burst_mask, burst_mask_n;
    logic [BA_WIDTH-1:0]   burst_ba, burst_ba_n;
    logic [ADDR_WIDTH-1:0] burst_row, burst_row_n;
    logic [COL_WIDTH-1:0]  burst_col, burst_col_n;

    logic                  issue_rd, issue_wr, flush;
    logic [BA_WIDTH-1:0]   beat_ba;
    logic [ADDR_WIDTH-1:0] beat_row;
    logic [COL_WIDTH-1:0]  beat_col;
    logic [FULL_AW-1:0]    full_addr;
    logic [MEM_AW-1:0]     beat_addr;

    logic [DATA_WIDTH-1:0] rd_data, rd_d1;
    logic                  rd_v0, rd_v1;
    logic                  mode_ok;

    function automatic logic [COL_WIDTH-1:0] col_wrap(input logic [COL_WIDTH-1:0] col,
                                                      input logic [2:0] mask,
                                                      input logic [2:0] idx);
        logic [2:0] lo;
        lo = (col[2:0] & ~mask) | ((col[2:0] + idx) & mask);
        return {col[COL_WIDTH-1:3], lo};
    endfunction

    always_comb cmd = cke ? decode_cmd(cs_n, ras_n, cas_n, we_n) : CMD_NOP;

    always_comb begin
        state_n      = state;
        beat_left_n  = beat_left;
        beat_idx_n   = beat_idx;
        burst_mask_n = burst_mask;
        burst_ba_n   = burst_ba;
        burst_row_n  = burst_row;
        burst_col_n  = burst_col;
        issue_rd     = 1'b0;
        issue_wr     = 1'b0;
        flush        = 1'b0;
        beat_ba      = burst_ba;
        beat_row     = burst_row;
        beat_col     = col_wrap(burst_col, burst_mask, beat_idx);

        if (state != ST_IDLE) begin
            issue_rd    = (state == ST_READ);
            issue_wr    = (state == ST_WRITE);
            beat_idx_n  = beat_idx + 3'd1;
            beat_left_n = beat_left - 3'd1;
            if (beat_left == 3'd1) state_n = ST_IDLE;
        end

        // A new column command pre-empts whatever beat the old burst would issue.
        if ((cmd == CMD_READ || cmd == CMD_WRITE) && bank_open[ba]) begin
            issue_rd     = (cmd == CMD_READ);
            issue_wr     = (cmd == CMD_WRITE);
            flush        = (cmd == CMD_WRITE);
            beat_ba      = ba;
            beat_row     = row_tbl[ba];
            beat_col     = addr[COL_WIDTH-1:0];
            burst_ba_n   = ba;
            burst_row_n  = row_tbl[ba];
            burst_col_n  = addr[COL_WIDTH-1:0];
            burst_mask_n = bl_mask(bl_code);
            beat_left_n  = bl_mask(bl_code);
            beat_idx_n   = 3'd1;
            if (bl_code == 2'd0)
                state_n = ST_IDLE;
            else
                state_n = (cmd == CMD_READ) ? ST_READ : ST_WRITE;
        end else if (cmd == CMD_PRECHARGE || cmd == CMD_BURST_STOP) begin
            issue_rd = 1'b0;
            issue_wr = 1'b0;
            flush    = 1'b1;
            state_n  = ST_IDLE;
        end
    end

    always_comb begin
        full_addr = {beat_ba, beat_row, beat_col};
        beat_addr = full_addr[MEM_AW-1:0];
    end

    always_comb begin
        mode_ok = (addr[MR_BL_MSB:MR_BL_LSB] <= BL_8) &&
                  (addr[MR_CL_MSB:MR_CL_LSB] == CL_2 || addr[MR_CL_MSB:MR_CL_LSB] == CL_3);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            beat_left   <= '0;
            beat_idx    <= '0;
            burst_mask  <= '0;
            burst_ba    <= '0;
            burst_row   <= '0;
            burst_col   <= '0;
            bank_open   <= '0;
            err         <= 1'b0;
            refresh_cnt <= '0;
            bl_code     <= BL_1[1:0];
            cl3         <= 1'b0;
        end else if (cke) begin
            state      <= state_n;
            beat_left  <= beat_left_n;
            beat_idx   <= beat_idx_n;
            burst_mask <= burst_mask_n;
            burst_ba   <= burst_ba_n;
            burst_row  <= burst_row_n;
            burst_col  <= burst_col_n;
            case (cmd)
                CMD_ACTIVE: begin
                    if (bank_open[ba]) err <= 1'b1;
                    else               bank_open[ba] <= 1'b1;
                end
                CMD_READ, CMD_WRITE: begin
                    if (!bank_open[ba]) err <= 1'b1;
                end
                CMD_PRECHARGE: begin
                    if (addr[PRE_ALL_BIT]) bank_open <= '0;
                    else                   bank_open[ba] <= 1'b0;
                end
                CMD_AUTO_REFRESH: begin
                    if (|bank_open)               err <= 1'b1;
                    else if (refresh_cnt != '1)   refresh_cnt <= refresh_cnt + 16'd1;
                end
                CMD_LOAD_MODE: begin
                    if (mode_ok) begin
                        bl_code <= addr[MR_BL_LSB +: 2];
                        cl3     <= (addr[MR_CL_MSB:MR_CL_LSB] == CL_3);
                    end else begin
                        err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (cke && cmd == CMD_ACTIVE && !bank_open[ba]) row_tbl[ba] <= addr;
    end

    // The store's read register is the first CAS stage; CL3 adds one more.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_v0  <= 1'b0;
            rd_v1  <= 1'b0;
            rd_d1  <= '0;
            dq_out <= '0;
            dq_oe  <= 1'b0;
        end else if (cke) begin
            if (flush) begin
                rd_v0  <= 1'b0;
                rd_v1  <= 1'b0;
                dq_out <= '0;
                dq_oe  <= 1'b0;
            end else begin
                rd_v0 <= issue_rd;
                rd_v1 <= rd_v0;
                rd_d1 <= rd_data;
                if (cl3) begin
                    dq_oe  <= rd_v1 && !(&dqm);
                    dq_out <= rd_v1 ? rd_d1 : '0;
                end else begin
                    dq_oe  <= rd_v0 && !(&dqm);
                    dq_out <= rd_v0 ? rd_data : '0;
                end
            end
        end
    end

    sdram_resp_store #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_AW     (MEM_AW)
    ) u_store (
        .clk   (clk),
        .en    (cke),
        .we    (issue_wr),
        .waddr (beat_addr),
        .wdata (dq_in),
        .wbe   (~dqm),
        .re    (issue_rd),
        .raddr (beat_addr),
        .rdata (rd_data)
    );

endmodule
